// File: rtl/pad_event_scheduler.sv
// Dance-pad front end: per-lane sync + debounce, press detection, and a
// round-robin serialiser that hands one lane event per valid/ready handshake.
module pad_event_scheduler #(
   parameter int unsigned DEBOUNCE = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [4:0] pad,
   input  logic       enable,
   input  logic       evt_ready,
   output logic       evt_valid,
   output logic [2:0] evt_code,
   output logic [4:0] lanes_held,
   output logic       overrun,
   input  logic       overrun_clr
);

   localparam int unsigned NUM_LANES = 5;
   localparam int unsigned CODE_W    = 3;
   localparam int unsigned CNT_W     = $clog2(DEBOUNCE) + 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE - 1);

   typedef enum logic {
      IDLE,
      PRESENT
   } state_e;

   state_e                 state_q, state_d;
   logic [NUM_LANES-1:0]   sync1_q, sync2_q;
   logic [NUM_LANES-1:0]   stable_q, stable_d;
   logic [CNT_W-1:0]       cnt_q [NUM_LANES];
   logic [CNT_W-1:0]       cnt_d [NUM_LANES];
   logic [NUM_LANES-1:0]   pending_q, pending_d;
   logic [CODE_W-1:0]      rr_last_q, rr_last_d;
   logic                   evt_valid_q, evt_valid_d;
   logic [CODE_W-1:0]      evt_code_q, evt_code_d;
   logic                   overrun_q, overrun_d;

   logic [NUM_LANES-1:0]   rise_c;
   logic [NUM_LANES-1:0]   press_c;
   logic                   found_c;
   logic [CODE_W-1:0]      grant_lane_c;
   logic [CODE_W-1:0]      search_idx_c;
   logic                   do_grant_c;
   logic [NUM_LANES-1:0]   grant_mask_c;

   // Lane index base+k, wrapping modulo the lane count (base is always 0..4).
   function automatic logic [CODE_W-1:0] wrap_add(input logic [CODE_W-1:0] base,
                                                  input int unsigned       k);
      logic [CODE_W:0] sum;
      sum = (CODE_W+1)'(base) + (CODE_W+1)'(k);
      if (sum >= (CODE_W+1)'(NUM_LANES)) sum = sum - (CODE_W+1)'(NUM_LANES);
      return sum[CODE_W-1:0];
   endfunction

   // Debounce: stable flips only after DEBOUNCE consecutive differing samples.
   always_comb begin
      stable_d = stable_q;
      rise_c   = '0;
      for (int i = 0; i < NUM_LANES; i++) begin
         cnt_d[i] = '0;
         if (sync2_q[i] != stable_q[i]) begin
            if (cnt_q[i] == CNT_MAX) begin
               stable_d[i] = sync2_q[i];
               rise_c[i]   = sync2_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
         end
      end
   end

   assign press_c = rise_c & {NUM_LANES{enable}};

   // Round-robin search starting just after the last granted lane.
   always_comb begin
      found_c      = 1'b0;
      grant_lane_c = '0;
      search_idx_c = '0;
      for (int unsigned k = 1; k <= NUM_LANES; k++) begin
         search_idx_c = wrap_add(rr_last_q, k);
         if (!found_c && pending_q[search_idx_c]) begin
            found_c      = 1'b1;
            grant_lane_c = search_idx_c;
         end
      end
   end

   // Next-state and output logic for the presentation FSM.
   always_comb begin
      state_d     = state_q;
      evt_valid_d = evt_valid_q;
      evt_code_d  = evt_code_q;
      rr_last_d   = rr_last_q;
      do_grant_c  = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (found_c) begin
               do_grant_c = 1'b1;
               state_d    = PRESENT;
            end
         end
         PRESENT: begin
            if (evt_ready) begin
               if (found_c) begin
                  do_grant_c = 1'b1;
               end else begin
                  state_d     = IDLE;
                  evt_valid_d = 1'b0;
                  evt_code_d  = '0;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      grant_mask_c = '0;
      if (do_grant_c) begin
         evt_valid_d  = 1'b1;
         evt_code_d   = grant_lane_c + CODE_W'(1);
         rr_last_d    = grant_lane_c;
         grant_mask_c = NUM_LANES'(1) << grant_lane_c;
      end

      // A press on the lane being granted re-arms it; on any other pending lane it merges.
      pending_d = (pending_q & ~grant_mask_c) | press_c;
      overrun_d = (|(press_c & pending_q & ~grant_mask_c)) | (overrun_q & ~overrun_clr);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         sync1_q     <= '0;
         sync2_q     <= '0;
         stable_q    <= '0;
         pending_q   <= '0;
         rr_last_q   <= CODE_W'(4);
         evt_valid_q <= 1'b0;
         evt_code_q  <= '0;
         overrun_q   <= 1'b0;
         for (int i = 0; i < NUM_LANES; i++) cnt_q[i] <= '0;
      end else begin
         state_q     <= state_d;
         sync1_q     <= pad;
         sync2_q     <= sync1_q;
         stable_q    <= stable_d;
         pending_q   <= pending_d;
         rr_last_q   <= rr_last_d;
         evt_valid_q <= evt_valid_d;
         evt_code_q  <= evt_code_d;
         overrun_q   <= overrun_d;
         for (int i = 0; i < NUM_LANES; i++) cnt_q[i] <= cnt_d[i];
      end
   end

   assign evt_valid  = evt_valid_q;
   assign evt_code   = evt_code_q;
   assign lanes_held = stable_q;
   assign overrun    = overrun_q;

endmodule

// File: tb/tb_pad_event_scheduler.sv
// Directed bench for pad_event_scheduler: latency, debounce, round-robin,
// backpressure, overrun and reset behaviour with DEBOUNCE=4.
module tb_pad_event_scheduler;

   logic       clk;
   logic       reset;
   logic [4:0] pad;
   logic       enable;
   logic       evt_ready;
   logic       evt_valid;
   logic [2:0] evt_code;
   logic [4:0] lanes_held;
   logic       overrun;
   logic       overrun_clr;

   int n_checks = 0;
   int n_fail   = 0;

   pad_event_scheduler #(.DEBOUNCE(4)) dut (
      .clk        (clk),
      .reset      (reset),
      .pad        (pad),
      .enable     (enable),
      .evt_ready  (evt_ready),
      .evt_valid  (evt_valid),
      .evt_code   (evt_code),
      .lanes_held (lanes_held),
      .overrun    (overrun),
      .overrun_clr(overrun_clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One rising edge, then settle before sampling or driving.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset       = 1'b1;
      pad         = '0;
      enable      = 1'b1;
      evt_ready   = 1'b0;
      overrun_clr = 1'b0;
      repeat (3) tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      n_checks++;
      if ({evt_valid, evt_code, lanes_held, overrun} !== 10'b0) begin
         n_fail++;
         $display("FAIL reset_state: got v=%b c=%b held=%b ovr=%b, want all 0",
                  evt_valid, evt_code, lanes_held, overrun);
      end
   endtask

   // Lane 2 pressed before edge 0: held from edge 5, single event at edge 6.
   task automatic test_single_press();
      logic [8:0] exp;
      do_reset();
      evt_ready = 1'b1;
      pad       = 5'b00100;
      for (int e = 0; e <= 9; e++) begin
         tick();
         exp = {(e == 6), (e == 6) ? 3'b011 : 3'b000, (e >= 5) ? 5'b00100 : 5'b00000};
         n_checks++;
         if ({evt_valid, evt_code, lanes_held} !== exp) begin
            n_fail++;
            $display("FAIL single_press edge %0d: got %b, want %b", e,
                     {evt_valid, evt_code, lanes_held}, exp);
         end
      end
      pad = '0;
      for (int e = 0; e <= 9; e++) begin
         tick();
         n_checks++;
         if (evt_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL release_no_event edge %0d: got valid=%b, want 0", e, evt_valid);
         end
      end
      n_checks++;
      if (lanes_held !== 5'b0) begin
         n_fail++;
         $display("FAIL release_held: got %b, want 00000", lanes_held);
      end
   endtask

   task automatic test_glitch();
      do_reset();
      evt_ready = 1'b1;
      pad       = 5'b00001;
      for (int e = 0; e < 15; e++) begin
         if (e == 3) pad = '0;
         tick();
         n_checks++;
         if ({evt_valid, lanes_held} !== 6'b0) begin
            n_fail++;
            $display("FAIL glitch edge %0d: got v=%b held=%b, want 0", e, evt_valid, lanes_held);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [3:0] exp;
      do_reset();
      evt_ready = 1'b1;
      pad       = 5'b11001;
      for (int e = 0; e <= 10; e++) begin
         tick();
         case (e)
            6:       exp = 4'b1_001;
            7:       exp = 4'b1_100;
            8:       exp = 4'b1_101;
            default: exp = 4'b0_000;
         endcase
         n_checks++;
         if ({evt_valid, evt_code} !== exp) begin
            n_fail++;
            $display("FAIL back_to_back edge %0d: got %b, want %b", e, {evt_valid, evt_code}, exp);
         end
      end
   endtask

   task automatic test_backpressure();
      do_reset();
      pad = 5'b00010;
      repeat (7) tick();
      for (int c = 0; c < 10; c++) begin
         n_checks++;
         if ({evt_valid, evt_code} !== 4'b1_010) begin
            n_fail++;
            $display("FAIL backpressure_hold cycle %0d: got %b, want 1010", c, {evt_valid, evt_code});
         end
         tick();
      end
      evt_ready = 1'b1;
      tick();
      n_checks++;
      if ({evt_valid, evt_code} !== 4'b0_000) begin
         n_fail++;
         $display("FAIL backpressure_accept: got %b, want 0000", {evt_valid, evt_code});
      end
   endtask

   task automatic test_round_robin();
      do_reset();
      evt_ready = 1'b1;
      pad       = 5'b01000;
      repeat (7) tick();
      n_checks++;
      if ({evt_valid, evt_code} !== 4'b1_100) begin
         n_fail++;
         $display("FAIL rr_first_lane3: got %b, want 1100", {evt_valid, evt_code});
      end
      pad = '0;
      repeat (10) tick();
      pad = 5'b10001;
      repeat (7) tick();
      n_checks++;
      if ({evt_valid, evt_code} !== 4'b1_101) begin
         n_fail++;
         $display("FAIL rr_lane4_first: got %b, want 1101", {evt_valid, evt_code});
      end
      tick();
      n_checks++;
      if ({evt_valid, evt_code} !== 4'b1_001) begin
         n_fail++;
         $display("FAIL rr_lane0_second: got %b, want 1001", {evt_valid, evt_code});
      end
      tick();
      n_checks++;
      if (evt_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL rr_drain: got valid=%b, want 0", evt_valid);
      end
   endtask

   task automatic test_enable_off();
      do_reset();
      evt_ready = 1'b1;
      enable    = 1'b0;
      pad       = 5'b00100;
      for (int e = 0; e <= 9; e++) begin
         tick();
         n_checks++;
         if (evt_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL enable_off_event edge %0d: got valid=%b, want 0", e, evt_valid);
         end
      end
      n_checks++;
      if (lanes_held !== 5'b00100) begin
         n_fail++;
         $display("FAIL enable_off_held: got %b, want 00100", lanes_held);
      end
      enable = 1'b1;
   endtask

   task automatic test_overrun_and_reset();
      do_reset();
      pad = 5'b00011;
      repeat (7) tick();
      n_checks++;
      if ({evt_valid, evt_code, overrun} !== 5'b1_001_0) begin
         n_fail++;
         $display("FAIL ovr_setup: got v=%b c=%b o=%b, want 1 001 0", evt_valid, evt_code, overrun);
      end
      pad = 5'b00001;
      repeat (10) tick();
      pad = 5'b00011;
      for (int e = 0; e <= 5; e++) begin
         tick();
         n_checks++;
         if ({evt_valid, evt_code, overrun} !== {4'b1_001, (e == 5)}) begin
            n_fail++;
            $display("FAIL ovr_repress edge %0d: got v=%b c=%b o=%b, want 1 001 %b",
                     e, evt_valid, evt_code, overrun, (e == 5));
         end
      end
      overrun_clr = 1'b1;
      tick();
      overrun_clr = 1'b0;
      n_checks++;
      if (overrun !== 1'b0) begin
         n_fail++;
         $display("FAIL ovr_clear: got %b, want 0", overrun);
      end
      reset = 1'b1;
      pad   = '0;
      tick();
      n_checks++;
      if ({evt_valid, evt_code, lanes_held} !== 9'b0) begin
         n_fail++;
         $display("FAIL reset_mid_present: got v=%b c=%b held=%b, want 0",
                  evt_valid, evt_code, lanes_held);
      end
      reset     = 1'b0;
      evt_ready = 1'b1;
      for (int e = 0; e < 8; e++) begin
         tick();
         n_checks++;
         if (evt_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_pending_cleared edge %0d: got valid=%b, want 0", e, evt_valid);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single_press();
      test_glitch();
      test_back_to_back();
      test_backpressure();
      test_round_robin();
      test_enable_off();
      test_overrun_and_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
